pw_conv_multi_ch_engine: RTL and testbench
==========================================

PW_CONV_MULTI_CH_ENGINE -- requirements
Module: pw_conv_multi_ch_engine

Interface
REQ-001 Parameter NUM_MACS, default 16, MAC lanes per beat.
REQ-002 Parameter DATA_W, default 8, activation/weight/quantised-output width.
REQ-003 Parameter ACC_W, default 32, accumulator width; SHALL be >= 2*DATA_W + clog2(1024).
REQ-004 Parameter CH_W, default 10, channel-count width.
REQ-005 Port clock  input  1  single clock; all state changes on rising edge.
REQ-006 Port reset_n  input  1  asynchronous, active-low reset.
REQ-007 Port cfg_num_in_ch  input  CH_W  input channels per output channel; sampled on accepted start.
REQ-008 Port cfg_num_out_ch  input  CH_W  output channels per job; sampled on accepted start.
REQ-009 Port cfg_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled on start.
REQ-010 Port cfg_relu  input  1  1 = clamp negative results to 0; sampled on start.
REQ-011 Port cfg_shift  input  5  requantisation right-shift; sampled on start.
REQ-012 Port start  input  1  single-cycle job request.
REQ-013 Port clear  input  1  synchronous abort to IDLE.
REQ-014 Port in_valid  input  1  beat of activations/weights valid.
REQ-015 Port in_ready  output  1  engine accepts beat this cycle.
REQ-016 Port in_act  input  NUM_MACS*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
REQ-017 Port in_wgt  input  NUM_MACS*DATA_W  same packing as in_act.
REQ-018 Port out_valid  output  1  result available.
REQ-019 Port out_ready  input  1  consumer accepts result.
REQ-020 Port out_acc  output  ACC_W  raw accumulator for current output channel.
REQ-021 Port out_q  output  DATA_W  requantised, saturated result.
REQ-022 Port out_ch_idx  output  CH_W  output-channel index of current result, 0-based.
REQ-023 Port busy  output  1  high in any state other than IDLE.
REQ-024 Port done  output  1  one-cycle pulse at job completion.

Function
REQ-025 FSM states IDLE, ACCUM, OUTPUT; IDLE -> ACCUM on start when cfg_num_in_ch != 0 and cfg_num_out_ch != 0.
REQ-026 start with either count zero: no state change, done pulses the next cycle, out_valid stays 0.
REQ-027 start while busy SHALL be ignored.
REQ-028 Beats per output channel B = ceil(cfg_num_in_ch / NUM_MACS); in_ready = 1 only in ACCUM.
REQ-029 Beat accepted when in_valid && in_ready; accumulator += sum of lane products, registered the same edge.
REQ-030 Last beat: lanes with index >= cfg_num_in_ch - (B-1)*NUM_MACS SHALL contribute 0 regardless of input data.
REQ-031 Products: DATA_W x DATA_W, sign-extended (cfg_signed=1) or zero-extended to ACC_W; accumulator wraps mod 2^ACC_W.
REQ-032 Edge accepting beat B: FSM -> OUTPUT; out_valid = 1 from the next cycle (1-cycle latency).
REQ-033 In OUTPUT: out_valid, out_acc, out_q, out_ch_idx SHALL hold stable until out_valid && out_ready.
REQ-034 On output handshake: if out_ch_idx < cfg_num_out_ch-1, accumulator clears, out_ch_idx increments, FSM -> ACCUM; else done pulses, FSM -> IDLE.
REQ-035 Requant: r = (acc + (cfg_shift ? 1<<(cfg_shift-1) : 0)) >>> cfg_shift (arithmetic if signed, logical if unsigned).
REQ-036 cfg_relu=1 and r<0: out_q = 0.
REQ-037 Saturation: signed mode to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; unsigned mode to [0, 2^DATA_W-1].
REQ-038 clear SHALL win over start, beat and output handshake in the same cycle; next cycle state IDLE, outputs at reset values, no done.

Reset
REQ-039 reset_n low asynchronously forces IDLE; in_ready, out_valid, busy, done = 0; out_acc, out_q, out_ch_idx, accumulator, beat counter = 0.
REQ-040 Reset mid-job discards all partial results; first start after release behaves as a fresh job.

Verification
REQ-041 Unsigned, in_ch=96, out_ch=1, all act=2, wgt=3, shift=4 -> 6 beats accepted, out_acc=576, out_q=36, done 1 cycle after handshake.
REQ-042 in_ch=20, all lanes driven act=1, wgt=1 on both beats -> out_acc=20 (lanes 4..15 of beat 2 masked).
REQ-043 Signed, in_ch=16, act=0x80, wgt=0x80, shift=0 -> out_acc=262144, out_q=127; act=0xFF, wgt=0x01, relu=1 -> out_acc=-16, out_q=0.
REQ-044 out_ch=3, out_ready low 5 cycles per result -> out_valid/out_acc stable while stalled, out_ch_idx 0,1,2, accumulator reset between channels, in_ready=0 during OUTPUT.
REQ-045 clear asserted on 3rd beat of 6 -> busy=0 next cycle, no out_valid, no done; restart gives correct result.
REQ-046 reset_n pulsed low mid-ACCUM -> all outputs 0 immediately; start with cfg_num_out_ch=0 -> done pulse, no out_valid.

Source files
------------

// File: rtl/pw_conv_multi_ch_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pw_conv_multi_ch_engine                                    |
// | Description : Pointwise (1x1) convolution engine. For each output        |
// |               channel it accumulates NUM_MACS lane products per beat     |
// |               over ceil(num_in_ch / NUM_MACS) beats, then presents the   |
// |               raw accumulator and a rounded, shifted, saturated          |
// |               DATA_W-bit result on a valid/ready output.                 |
// | Ports       : clock, reset_n (async, active-low)                         |
// |               cfg_num_in_ch, cfg_num_out_ch, cfg_signed, cfg_relu,       |
// |               cfg_shift   : job configuration, captured on start         |
// |               start, clear: job request / synchronous abort              |
// |               in_valid, in_ready, in_act, in_wgt : operand beat stream   |
// |               out_valid, out_ready, out_acc, out_q, out_ch_idx : result  |
// |               busy, done  : status                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pw_conv_multi_ch_engine #(
  parameter int NUM_MACS = 16,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int CH_W     = 10
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [CH_W-1:0]            cfg_num_in_ch,
  input  logic [CH_W-1:0]            cfg_num_out_ch,
  input  logic                       cfg_signed,
  input  logic                       cfg_relu,
  input  logic [4:0]                 cfg_shift,
  input  logic                       start,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_MACS*DATA_W-1:0] in_act,
  input  logic [NUM_MACS*DATA_W-1:0] in_wgt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_acc,
  output logic [DATA_W-1:0]          out_q,
  output logic [CH_W-1:0]            out_ch_idx,
  output logic                       busy,
  output logic                       done
);

  // Channel-position width: enough for beat index * NUM_MACS + NUM_MACS.
  localparam int BASE_W = CH_W + $clog2(NUM_MACS) + 1;
  // Signed product of two (DATA_W+1)-bit operands (extra bit carries the
  // signed/unsigned extension so one multiplier serves both modes).
  localparam int PROD_W = 2 * DATA_W + 2;
  // Requantisation headroom: sign bit plus rounding carry.
  localparam int EXT_W  = ACC_W + 2;

  localparam logic signed [EXT_W-1:0] S_MAX = EXT_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] S_MIN = -S_MAX - EXT_W'(1);
  localparam logic signed [EXT_W-1:0] U_MAX = EXT_W'((2 ** DATA_W) - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CH_W-1:0]   beat_q, beat_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [CH_W-1:0]   num_in_q, num_in_d;
  logic [CH_W-1:0]   num_out_q, num_out_d;
  logic              signed_q, signed_d;
  logic              relu_q, relu_d;
  logic [4:0]        shift_q, shift_d;
  logic              done_q, done_d;

  // ---------------------------------------------------------------- datapath
  logic [BASE_W-1:0] beat_base;
  logic              last_beat;
  logic [ACC_W-1:0]  lane_prod [NUM_MACS];
  logic [ACC_W-1:0]  beat_sum;

  // First input-channel number covered by the current beat.
  assign beat_base = BASE_W'(beat_q) * BASE_W'(NUM_MACS);
  assign last_beat = (beat_base + BASE_W'(NUM_MACS)) >= BASE_W'(num_in_q);

  for (genvar i = 0; i < NUM_MACS; i++) begin : g_lane
    logic [DATA_W-1:0]        a;
    logic [DATA_W-1:0]        w;
    logic signed [DATA_W:0]   a_ext;
    logic signed [DATA_W:0]   w_ext;
    logic signed [PROD_W-1:0] prod;
    logic                     lane_en;

    assign a     = in_act[i*DATA_W +: DATA_W];
    assign w     = in_wgt[i*DATA_W +: DATA_W];
    assign a_ext = $signed({signed_q & a[DATA_W-1], a});
    assign w_ext = $signed({signed_q & w[DATA_W-1], w});
    assign prod  = a_ext * w_ext;
    // Lanes past the last real input channel are masked on the final beat.
    assign lane_en = (beat_base + BASE_W'(i)) < BASE_W'(num_in_q);
    assign lane_prod[i] = lane_en ? {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod} : '0;
  end

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < NUM_MACS; i++) begin
      beat_sum = beat_sum + lane_prod[i];
    end
  end

  // ------------------------------------------------------------ requantise
  logic [EXT_W-1:0]        acc_ext;
  logic [EXT_W-1:0]        rnd;
  logic [EXT_W-1:0]        rsum;
  logic signed [EXT_W-1:0] r;
  logic [DATA_W-1:0]       q;

  assign acc_ext = {{2{signed_q & acc_q[ACC_W-1]}}, acc_q};
  assign rnd     = (shift_q != 5'd0) ? (EXT_W'(1) << (shift_q - 5'd1)) : '0;
  assign rsum    = acc_ext + rnd;

  always_comb begin
    // Kept as separate branches: a ternary would make the whole expression
    // unsigned and silently turn >>> into a logical shift.
    r = '0;
    if (signed_q) begin
      r = $signed(rsum) >>> shift_q;
    end else begin
      r = $signed(rsum >> shift_q);
    end
  end

  always_comb begin
    q = '0;
    if (relu_q && (r < 0)) begin
      q = '0;
    end else if (signed_q) begin
      if (r > S_MAX)      q = S_MAX[DATA_W-1:0];
      else if (r < S_MIN) q = S_MIN[DATA_W-1:0];
      else                q = r[DATA_W-1:0];
    end else begin
      if (r > U_MAX) q = U_MAX[DATA_W-1:0];
      else           q = r[DATA_W-1:0];
    end
  end

  // ------------------------------------------------------------ next state
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    beat_d    = beat_q;
    out_ch_d  = out_ch_q;
    num_in_d  = num_in_q;
    num_out_d = num_out_q;
    signed_d  = signed_q;
    relu_d    = relu_q;
    shift_d   = shift_q;
    done_d    = 1'b0;

    if (clear) begin
      state_d  = ST_IDLE;
      acc_d    = '0;
      beat_d   = '0;
      out_ch_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if ((cfg_num_in_ch != '0) && (cfg_num_out_ch != '0)) begin
              state_d   = ST_ACCUM;
              acc_d     = '0;
              beat_d    = '0;
              out_ch_d  = '0;
              num_in_d  = cfg_num_in_ch;
              num_out_d = cfg_num_out_ch;
              signed_d  = cfg_signed;
              relu_d    = cfg_relu;
              shift_d   = cfg_shift;
            end else begin
              // Empty job: report completion without producing results.
              done_d = 1'b1;
            end
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            acc_d = acc_q + beat_sum;
            if (last_beat) begin
              state_d = ST_OUTPUT;
              beat_d  = '0;
            end else begin
              beat_d = beat_q + CH_W'(1);
            end
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            if (out_ch_q == (num_out_q - CH_W'(1))) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d  = ST_ACCUM;
              acc_d    = '0;
              out_ch_d = out_ch_q + CH_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      beat_q    <= '0;
      out_ch_q  <= '0;
      num_in_q  <= '0;
      num_out_q <= '0;
      signed_q  <= 1'b0;
      relu_q    <= 1'b0;
      shift_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      beat_q    <= beat_d;
      out_ch_q  <= out_ch_d;
      num_in_q  <= num_in_d;
      num_out_q <= num_out_d;
      signed_q  <= signed_d;
      relu_q    <= relu_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign in_ready   = (state_q == ST_ACCUM);
  assign out_valid  = (state_q == ST_OUTPUT);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign out_acc    = acc_q;
  assign out_q      = q;
  assign out_ch_idx = out_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_pw_conv_multi_ch_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pw_conv_multi_ch_engine                                 |
// | Description : Self-checking bench for pw_conv_multi_ch_engine: directed  |
// |               vector table, random jobs against a channel-level          |
// |               arithmetic model, and hand sequences for clear/reset/empty |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pw_conv_multi_ch_engine;

  localparam int N   = 16;
  localparam int DW  = 8;
  localparam int AW  = 32;
  localparam int CW  = 10;
  localparam int TMO = 50;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [CW-1:0]   cfg_num_in_ch = '0;
  logic [CW-1:0]   cfg_num_out_ch = '0;
  logic            cfg_signed = 1'b0;
  logic            cfg_relu = 1'b0;
  logic [4:0]      cfg_shift = '0;
  logic            start = 1'b0;
  logic            clear = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*DW-1:0] in_act = '0;
  logic [N*DW-1:0] in_wgt = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [AW-1:0]   out_acc;
  logic [DW-1:0]   out_q;
  logic [CW-1:0]   out_ch_idx;
  logic            busy;
  logic            done;

  pw_conv_multi_ch_engine #(.NUM_MACS(N), .DATA_W(DW), .ACC_W(AW), .CH_W(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .cfg_num_in_ch(cfg_num_in_ch), .cfg_num_out_ch(cfg_num_out_ch),
    .cfg_signed(cfg_signed), .cfg_relu(cfg_relu), .cfg_shift(cfg_shift),
    .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_q(out_q),
    .out_ch_idx(out_ch_idx), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Operands per output channel, indexed by input-channel number.
  logic [7:0] act_mem [0:3][0:127];
  logic [7:0] wgt_mem [0:3][0:127];

  typedef struct {
    bit         sgn;
    bit         relu;
    int         shift;
    int         n_in;
    int         n_out;
    int         stall;
    logic [7:0] act;
    logic [7:0] wgt;
    logic [31:0] exp_acc;
    logic [7:0]  exp_q;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: dot product over the real input channels, wrapped to 32 bits,
  // then round-half-up shift, optional ReLU and saturation.
  function automatic void model(input int o, input bit sgn, input bit relu, input int shift,
                                input int n_in, output logic [31:0] ea, output logic [7:0] eq);
    longint s = 0;
    longint a, w, v;
    for (int ch = 0; ch < n_in; ch++) begin
      if (sgn) begin
        a = longint'($signed(act_mem[o][ch]));
        w = longint'($signed(wgt_mem[o][ch]));
      end else begin
        a = longint'({56'd0, act_mem[o][ch]});
        w = longint'({56'd0, wgt_mem[o][ch]});
      end
      s = s + a * w;
    end
    ea = s[31:0];
    if (sgn) v = longint'($signed(ea));
    else     v = $signed({32'd0, ea});
    if (shift > 0) v = (v + (longint'(1) << (shift - 1))) >>> shift;
    if (relu && v < 0)      v = 0;
    else if (sgn) begin
      if (v > 127)       v = 127;
      else if (v < -128) v = -128;
    end else if (v > 255) v = 255;
    eq = v[7:0];
  endfunction

  task automatic fill_const(input logic [7:0] a, input logic [7:0] w);
    for (int o = 0; o < 4; o++)
      for (int c = 0; c < 128; c++) begin
        act_mem[o][c] = a;
        wgt_mem[o][c] = w;
      end
  endtask

  task automatic fill_rand();
    for (int o = 0; o < 4; o++)
      for (int c = 0; c < 128; c++) begin
        act_mem[o][c] = 8'($urandom);
        wgt_mem[o][c] = 8'($urandom);
      end
  endtask

  task automatic send_beat(input int o, input int b, output bit ok);
    int t = 0;
    for (int i = 0; i < N; i++) begin
      in_act[i*DW +: DW] = act_mem[o][b*N + i];
      in_wgt[i*DW +: DW] = wgt_mem[o][b*N + i];
    end
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < TMO) begin
      tick();
      t++;
    end
    if (t >= TMO) begin
      n_cmp++;
      n_err++;
      $display("FAIL beat_timeout: got in_ready=%b expected 1", in_ready);
      in_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    in_act = {4{32'($urandom)}};
    in_wgt = {4{32'($urandom)}};
    ok = 1'b1;
  endtask

  task automatic pulse_start(input bit sgn, input bit relu, input int shift,
                             input int n_in, input int n_out);
    cfg_signed     = sgn;
    cfg_relu       = relu;
    cfg_shift      = 5'(shift);
    cfg_num_in_ch  = CW'(n_in);
    cfg_num_out_ch = CW'(n_out);
    start = 1'b1;
    tick();
    start = 1'b0;
    // Configuration must have been captured; scramble it.
    cfg_signed     = 1'($urandom);
    cfg_relu       = 1'($urandom);
    cfg_shift      = 5'($urandom);
    cfg_num_in_ch  = CW'($urandom);
    cfg_num_out_ch = CW'($urandom);
  endtask

  task automatic run_job(input string tag, input bit sgn, input bit relu, input int shift,
                         input int n_in, input int n_out, input int stall, input bit poke,
                         input bit use_exp, input logic [31:0] x_acc, input logic [7:0] x_q);
    logic [31:0] ea;
    logic [7:0]  eq;
    bit ok;
    int nb = (n_in + N - 1) / N;
    pulse_start(sgn, relu, shift, n_in, n_out);
    chk($sformatf("%s.busy", tag), 64'(busy), 64'd1);
    for (int o = 0; o < n_out; o++) begin
      if (use_exp) begin
        ea = x_acc;
        eq = x_q;
      end else model(o, sgn, relu, shift, n_in, ea, eq);
      chk($sformatf("%s.ch%0d.acc_clr", tag, o), 64'(out_acc), 64'd0);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send_beat(o, b, ok);
        if (!ok) return;
        if (poke && o == 0 && b == 0 && nb > 1) begin
          // A start while busy must not disturb the running job.
          cfg_num_in_ch = 10'd1;
          cfg_num_out_ch = 10'd1;
          start = 1'b1;
          tick();
          start = 1'b0;
        end
      end
      chk($sformatf("%s.ch%0d.valid", tag, o), 64'(out_valid), 64'd1);
      chk($sformatf("%s.ch%0d.in_ready", tag, o), 64'(in_ready), 64'd0);
      chk($sformatf("%s.ch%0d.acc", tag, o), 64'(out_acc), 64'(ea));
      chk($sformatf("%s.ch%0d.q", tag, o), 64'(out_q), 64'(eq));
      chk($sformatf("%s.ch%0d.idx", tag, o), 64'(out_ch_idx), 64'(o));
      for (int s = 0; s < stall; s++) begin
        out_ready = 1'b0;
        tick();
        chk($sformatf("%s.ch%0d.stall_valid", tag, o), 64'(out_valid), 64'd1);
        chk($sformatf("%s.ch%0d.stall_acc", tag, o), 64'(out_acc), 64'(ea));
        chk($sformatf("%s.ch%0d.stall_q", tag, o), 64'(out_q), 64'(eq));
        chk($sformatf("%s.ch%0d.stall_idx", tag, o), 64'(out_ch_idx), 64'(o));
        chk($sformatf("%s.ch%0d.stall_rdy", tag, o), 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (o == n_out - 1) begin
        chk($sformatf("%s.done", tag), 64'(done), 64'd1);
        chk($sformatf("%s.idle", tag), 64'(busy), 64'd0);
        chk($sformatf("%s.valid_off", tag), 64'(out_valid), 64'd0);
        tick();
        chk($sformatf("%s.done_pulse", tag), 64'(done), 64'd0);
      end else begin
        chk($sformatf("%s.ch%0d.no_done", tag, o), 64'(done), 64'd0);
        chk($sformatf("%s.ch%0d.reaccum", tag, o), 64'(in_ready), 64'd1);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk($sformatf("%s.in_ready", tag), 64'(in_ready), 64'd0);
    chk($sformatf("%s.out_valid", tag), 64'(out_valid), 64'd0);
    chk($sformatf("%s.busy", tag), 64'(busy), 64'd0);
    chk($sformatf("%s.done", tag), 64'(done), 64'd0);
    chk($sformatf("%s.out_acc", tag), 64'(out_acc), 64'd0);
    chk($sformatf("%s.out_q", tag), 64'(out_q), 64'd0);
    chk($sformatf("%s.out_ch_idx", tag), 64'(out_ch_idx), 64'd0);
  endtask

  initial begin
    bit ok;
    //           sgn relu sh n_in n_out stall act    wgt    exp_acc        exp_q
    tbl[0] = '{1'b0, 1'b0, 4, 96, 1, 0, 8'h02, 8'h03, 32'd576,       8'd36};
    tbl[1] = '{1'b0, 1'b0, 0, 20, 1, 1, 8'h01, 8'h01, 32'd20,        8'd20};
    tbl[2] = '{1'b1, 1'b0, 0, 16, 1, 0, 8'h80, 8'h80, 32'd262144,    8'd127};
    tbl[3] = '{1'b1, 1'b1, 0, 16, 1, 0, 8'hFF, 8'h01, 32'hFFFF_FFF0, 8'd0};
    tbl[4] = '{1'b1, 1'b0, 2, 16, 1, 0, 8'hFF, 8'h01, 32'hFFFF_FFF0, 8'hFC};
    tbl[5] = '{1'b0, 1'b0, 0, 16, 1, 0, 8'hFF, 8'hFF, 32'd1040400,   8'd255};
    tbl[6] = '{1'b0, 1'b0, 12, 16, 1, 2, 8'hFF, 8'hFF, 32'd1040400,  8'd254};
    tbl[7] = '{1'b1, 1'b0, 10, 3, 1, 0, 8'h7F, 8'h7F, 32'd48387,     8'd47};
    tbl[8] = '{1'b0, 1'b0, 0, 16, 3, 5, 8'h01, 8'h02, 32'd32,        8'd32};

    // Reset state
    tick();
    tick();
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // Directed table
    for (int k = 0; k < 9; k++) begin
      fill_const(tbl[k].act, tbl[k].wgt);
      run_job($sformatf("vec%0d", k), tbl[k].sgn, tbl[k].relu, tbl[k].shift, tbl[k].n_in,
              tbl[k].n_out, tbl[k].stall, 1'b0, 1'b1, tbl[k].exp_acc, tbl[k].exp_q);
    end

    // Random jobs against the model
    for (int k = 0; k < 25; k++) begin
      fill_rand();
      run_job($sformatf("rnd%0d", k), 1'($urandom), 1'($urandom), int'($urandom_range(0, 20)),
              int'($urandom_range(1, 128)), int'($urandom_range(1, 3)),
              int'($urandom_range(0, 3)), 1'($urandom), 1'b0, 32'd0, 8'd0);
    end

    // Clear on the third of six beats
    fill_const(8'h02, 8'h03);
    pulse_start(1'b0, 1'b0, 4, 96, 1);
    send_beat(0, 0, ok);
    send_beat(0, 1, ok);
    in_valid = 1'b1;
    clear = 1'b1;
    out_ready = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk_all_zero("clear");
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("clear.after%0d.valid", c), 64'(out_valid), 64'd0);
      chk($sformatf("clear.after%0d.done", c), 64'(done), 64'd0);
    end
    run_job("clear_restart", 1'b0, 1'b0, 4, 96, 1, 0, 1'b0, 1'b1, 32'd576, 8'd36);

    // Asynchronous reset in the middle of accumulation
    fill_const(8'h05, 8'h07);
    pulse_start(1'b1, 1'b0, 3, 64, 2);
    send_beat(0, 0, ok);
    send_beat(0, 1, ok);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    tick();
    #2;
    reset_n = 1'b1;
    tick();
    chk_all_zero("after_reset");
    fill_rand();
    run_job("fresh", 1'b1, 1'b0, 5, 40, 2, 1, 1'b0, 1'b0, 32'd0, 8'd0);

    // Empty jobs
    pulse_start(1'b0, 1'b0, 0, 5, 0);
    chk("empty_out.done", 64'(done), 64'd1);
    chk("empty_out.busy", 64'(busy), 64'd0);
    chk("empty_out.valid", 64'(out_valid), 64'd0);
    tick();
    chk("empty_out.done_pulse", 64'(done), 64'd0);
    pulse_start(1'b0, 1'b0, 0, 0, 3);
    chk("empty_in.done", 64'(done), 64'd1);
    chk("empty_in.in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("empty_in.done_pulse", 64'(done), 64'd0);
    chk("empty_in.valid", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
